// File: rtl/xor_apuf_pkg.sv
// Shared types and width helpers for the XOR arbiter-PUF controller.
package xor_apuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FIRE,
    WAIT,
    SAMPLE,
    RELAX,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold every value 0..max_val (at least 1 bit).
  function automatic int cnt_w(input int max_val);
    int w;
    w = clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/maj_vote_acc.sv
// Bank of WIDTH ones-counters; vote[i] is set when bit i was 1 in more than half of REPS samples.
module maj_vote_acc
  import xor_apuf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REPS  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] vote
);

  localparam int CW = cnt_w(REPS);
  localparam logic [CW-1:0] HALF = CW'(REPS / 2);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (inc && bits[i]) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign vote[i] = (cnt > HALF);
  end

endmodule

// File: rtl/xor_apuf_ctrl.sv
// Sequences one K-way XOR arbiter-PUF: settle, REPS trigger pulses, majority vote, timeout abort.
module xor_apuf_ctrl
  import xor_apuf_pkg::*;
#(
  parameter int N           = 16,
  parameter int K           = 8,
  parameter int REPS        = 5,
  parameter int SETTLE_CYC  = 4,
  parameter int RELAX_CYC   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         chal_valid,
  output logic         chal_ready,
  input  logic [N-1:0] chal,
  output logic [N-1:0] puf_c,
  output logic         puf_tig,
  input  logic         puf_resp_ready,
  input  logic [K-1:0] puf_resp_a,
  input  logic         puf_resp,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_bit,
  output logic [K-1:0] rsp_bits,
  output logic         rsp_timeout,
  output logic         busy
);

  localparam int RW = cnt_w(REPS);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int XW = cnt_w(RELAX_CYC);
  localparam int TW = cnt_w(TIMEOUT_CYC);

  localparam logic [RW-1:0] REPS_V       = RW'(REPS);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [XW-1:0] RELAX_LAST   = XW'(RELAX_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [XW-1:0] relax_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] rep;
  logic          abort;

  logic          accept;
  logic [K-1:0]  vote_a;
  logic [0:0]    vote_x;

  assign chal_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = chal_valid && chal_ready;

  maj_vote_acc #(.WIDTH(K), .REPS(REPS)) u_vote_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .inc   (state == SAMPLE),
    .bits  (puf_resp_a),
    .vote  (vote_a)
  );

  maj_vote_acc #(.WIDTH(1), .REPS(REPS)) u_vote_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .inc   (state == SAMPLE),
    .bits  (puf_resp),
    .vote  (vote_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      puf_c       <= '0;
      puf_tig     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_bit     <= 1'b0;
      rsp_bits    <= '0;
      rsp_timeout <= 1'b0;
      settle_cnt  <= '0;
      relax_cnt   <= '0;
      tmo_cnt     <= '0;
      rep         <= '0;
      abort       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid) begin
            puf_c      <= chal;
            rep        <= '0;
            settle_cnt <= '0;
            abort      <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          puf_tig <= 1'b0;
          // A ready flag still high from a stuck arbiter would fake the first sample.
          if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else if (!puf_resp_ready) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          puf_tig <= 1'b1;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (puf_resp_ready) begin
            state <= SAMPLE;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            abort     <= 1'b1;
            puf_tig   <= 1'b0;
            relax_cnt <= '0;
            state     <= RELAX;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          rep       <= rep + 1'b1;
          puf_tig   <= 1'b0;
          relax_cnt <= '0;
          state     <= RELAX;
        end
        RELAX: begin
          if (relax_cnt != RELAX_LAST) begin
            relax_cnt <= relax_cnt + 1'b1;
          end else if (!puf_resp_ready) begin
            if (abort || rep == REPS_V) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= abort;
              rsp_bits    <= abort ? '0 : vote_a;
              rsp_bit     <= abort ? 1'b0 : vote_x[0];
              state       <= DONE;
            end else begin
              state <= FIRE;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_apuf_ctrl.sv
// Directed + randomized bench for xor_apuf_ctrl with a behavioural PUF and a majority-vote model.
module tb_xor_apuf_ctrl;

  localparam int N           = 16;
  localparam int K           = 8;
  localparam int REPS        = 5;
  localparam int SETTLE_CYC  = 4;
  localparam int RELAX_CYC   = 4;
  localparam int TIMEOUT_CYC = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         chal_valid;
  logic         chal_ready;
  logic [N-1:0] chal;
  logic [N-1:0] puf_c;
  logic         puf_tig;
  logic         puf_resp_ready;
  logic [K-1:0] puf_resp_a;
  logic         puf_resp;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_bit;
  logic [K-1:0] rsp_bits;
  logic         rsp_timeout;
  logic         busy;

  always #5 clk = ~clk;

  xor_apuf_ctrl #(
    .N(N), .K(K), .REPS(REPS), .SETTLE_CYC(SETTLE_CYC),
    .RELAX_CYC(RELAX_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chal_valid     (chal_valid),
    .chal_ready     (chal_ready),
    .chal           (chal),
    .puf_c          (puf_c),
    .puf_tig        (puf_tig),
    .puf_resp_ready (puf_resp_ready),
    .puf_resp_a     (puf_resp_a),
    .puf_resp       (puf_resp),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_bit        (rsp_bit),
    .rsp_bits       (rsp_bits),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Written only by the main sequence.
  int           mode      = 0;   // 0 normal, 1 never ready, 2 ready stuck high
  int           puf_delay = 3;
  int           txn_seq   = 0;
  logic [K-1:0] tab_a [REPS];
  logic         tab_x [REPS];

  // Written only by the PUF model.
  int   rep_idx, tig_rises, relax_viol, last_high, cur_high, low_run, wait_cnt, seen_seq;
  logic tig_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Majority over the REPS responses the PUF model was told to return.
  function automatic logic [K:0] model_result(input bit aborted);
    logic [K:0] r;
    int ones;
    r = '0;
    if (!aborted) begin
      for (int i = 0; i < K; i++) begin
        ones = 0;
        for (int j = 0; j < REPS; j++) ones += int'(tab_a[j][i]);
        r[i] = (ones * 2 > REPS);
      end
      ones = 0;
      for (int j = 0; j < REPS; j++) ones += int'(tab_x[j]);
      r[K] = (ones * 2 > REPS);
    end
    return r;
  endfunction

  initial begin : puf_model
    puf_resp_ready = 1'b0;
    puf_resp_a     = '0;
    puf_resp       = 1'b0;
    rep_idx = 0; tig_rises = 0; relax_viol = 0; last_high = 0;
    cur_high = 0; low_run = 1000; wait_cnt = 0; seen_seq = 0; tig_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (seen_seq != txn_seq) begin
        seen_seq = txn_seq; rep_idx = 0; tig_rises = 0; relax_viol = 0; last_high = 0;
      end
      if (puf_tig && !tig_prev) begin
        tig_rises++;
        if (low_run < RELAX_CYC) relax_viol++;
        cur_high = 0;
        wait_cnt = 0;
      end
      if (puf_tig) begin
        low_run = 0;
        cur_high++;
        wait_cnt++;
        if (mode == 0 && wait_cnt >= puf_delay && !puf_resp_ready) begin
          puf_resp_a     = tab_a[rep_idx % REPS];
          puf_resp       = tab_x[rep_idx % REPS];
          puf_resp_ready = 1'b1;
          rep_idx++;
        end
      end else begin
        if (tig_prev) last_high = cur_high;
        low_run++;
        puf_resp_ready = 1'b0;
      end
      if (mode == 2) puf_resp_ready = 1'b1;
      tig_prev = puf_tig;
    end
  end

  task automatic randomize_tabs();
    for (int j = 0; j < REPS; j++) begin
      tab_a[j] = K'($urandom);
      tab_x[j] = 1'($urandom);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_chal(input logic [N-1:0] c, input bit chk_lat, input string tag);
    int guard;
    int lat;
    txn_seq++;
    chal       = c;
    chal_valid = 1'b1;
    guard      = 0;
    while (!chal_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!chal_ready) check({tag, "_accept"}, 32'(chal_ready), 32'd1);
    @(negedge clk);
    chal_valid = 1'b0;
    check({tag, "_puf_c"}, 32'(puf_c), 32'(c));
    if (chal_lat_needed(chk_lat)) begin
      lat = 0;
      while (!puf_tig && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check({tag, "_first_tig_latency"}, 32'(lat), 32'(SETTLE_CYC + 1));
    end
  endtask

  function automatic bit chal_lat_needed(input bit b);
    return b;
  endfunction

  task automatic wait_rsp(input string tag);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) check({tag, "_rsp_valid_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input bit aborted, input int exp_rises);
    logic [K:0] exp;
    exp = model_result(aborted);
    check({tag, "_rsp_bits"},    32'(rsp_bits),    32'(exp[K-1:0]));
    check({tag, "_rsp_bit"},     32'(rsp_bit),     32'(exp[K]));
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(aborted));
    check({tag, "_tig_rises"},   32'(tig_rises),   32'(exp_rises));
    check({tag, "_relax_low"},   32'(relax_viol),  32'd0);
  endtask

  // With rsp_ready high the response lasts one cycle and chal_ready returns next cycle.
  task automatic finish_rsp(input string tag);
    @(negedge clk);
    check({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_chal_ready_back"}, 32'(chal_ready), 32'd1);
  endtask

  task automatic run_txn(input logic [N-1:0] c, input string tag);
    send_chal(c, 1'b1, tag);
    wait_rsp(tag);
    check_result(tag, 1'b0, REPS);
    finish_rsp(tag);
  endtask

  initial begin : main_seq
    logic [N-1:0] c1, c2;
    logic [K-1:0] hold_bits;
    logic         hold_bit;
    int           guard;

    rst_n = 1'b0; chal_valid = 1'b0; chal = '0; rsp_ready = 1'b1;
    for (int j = 0; j < REPS; j++) begin tab_a[j] = '0; tab_x[j] = 1'b0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_chal_ready", 32'(chal_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_puf_tig", 32'(puf_tig), 32'd0);
    check("reset_puf_c", 32'(puf_c), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_bits", 32'(rsp_bits), 32'd0);
    check("reset_rsp_bit", 32'(rsp_bit), 32'd0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);

    // Directed majority pattern.
    tab_a[0] = 8'hFF; tab_a[1] = 8'h00; tab_a[2] = 8'hFF; tab_a[3] = 8'h0F; tab_a[4] = 8'hFF;
    tab_x[0] = 1'b1;  tab_x[1] = 1'b0;  tab_x[2] = 1'b1;  tab_x[3] = 1'b0;  tab_x[4] = 1'b0;
    puf_delay = 3;
    run_txn(16'hA5A5, "majority");

    // Randomized responses and arbiter delays.
    for (int t = 0; t < 6; t++) begin
      randomize_tabs();
      puf_delay = int'($urandom_range(1, 8));
      run_txn(N'($urandom), $sformatf("rand%0d", t));
    end

    // Arbiter never answers.
    mode = 1;
    send_chal(16'h1234, 1'b1, "timeout");
    wait_rsp("timeout");
    check_result("timeout", 1'b1, 1);
    check("timeout_tig_high_len", 32'(last_high), 32'(TIMEOUT_CYC));
    finish_rsp("timeout");
    mode = 0;

    // Timeout on the third repetition throws away the two good votes.
    for (int j = 0; j < REPS; j++) begin tab_a[j] = 8'hFF; tab_x[j] = 1'b1; end
    puf_delay = 4;
    send_chal(16'h0F0F, 1'b1, "late_tmo");
    guard = 0;
    while (tig_rises < 3 && guard < 500) begin @(negedge clk); guard++; end
    mode = 1;
    wait_rsp("late_tmo");
    check_result("late_tmo", 1'b1, 3);
    finish_rsp("late_tmo");
    mode = 0;

    // Host backpressure on the response.
    randomize_tabs();
    puf_delay = 2;
    c1 = 16'hBEEF; c2 = 16'hC0DE;
    rsp_ready = 1'b0;
    send_chal(c1, 1'b1, "bp");
    wait_rsp("bp");
    check_result("bp", 1'b0, REPS);
    hold_bits = rsp_bits; hold_bit = rsp_bit;
    chal = c2; chal_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'({rsp_bit, rsp_bits}), 32'({hold_bit, hold_bits}));
      check("bp_chal_ready_low", 32'(chal_ready), 32'd0);
      check("bp_puf_c_hold", 32'(puf_c), 32'(c1));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_chal_ready", 32'(chal_ready), 32'd1);
    check("bp_release_puf_c", 32'(puf_c), 32'(c1));
    @(negedge clk);
    chal_valid = 1'b0;
    txn_seq++;
    check("bp_next_puf_c", 32'(puf_c), 32'(c2));
    check("bp_next_busy", 32'(busy), 32'd1);
    wait_rsp("bp_next");
    check_result("bp_next", 1'b0, REPS);
    finish_rsp("bp_next");

    // Ready stuck high when settling: no trigger until it drops.
    randomize_tabs();
    puf_delay = 3;
    mode = 2;
    send_chal(16'h5A5A, 1'b0, "stuck");
    repeat (30) @(negedge clk);
    check("stuck_no_tig_rise", 32'(tig_rises), 32'd0);
    check("stuck_tig_low", 32'(puf_tig), 32'd0);
    check("stuck_busy", 32'(busy), 32'd1);
    mode = 0;
    wait_rsp("stuck");
    check_result("stuck", 1'b0, REPS);
    finish_rsp("stuck");

    // Asynchronous reset while the trigger is high.
    mode = 1;
    send_chal(16'h7777, 1'b1, "arst");
    guard = 0;
    while (!puf_tig && guard < 50) begin @(negedge clk); guard++; end
    check("arst_tig_high_before", 32'(puf_tig), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tig_async", 32'(puf_tig), 32'd0);
    check("arst_valid_async", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(negedge clk);
    check("arst_chal_ready", 32'(chal_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_puf_c", 32'(puf_c), 32'd0);

    randomize_tabs();
    puf_delay = 5;
    run_txn(16'h9C3E, "post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
